// File: rtl/io_pkg.sv
// Shared types and constants for the CPU-side UART I/O controller.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int TO_CNT_W     = $clog2(BUSY_TIMEOUT + 1);

  // True on the last cycle uart_tx is given to raise busy after a start strobe.
  function automatic logic busy_timed_out(input logic [TO_CNT_W-1:0] cnt);
    return cnt == TO_CNT_W'(BUSY_TIMEOUT - 1);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO, 2^AW entries of W bits, combinational head, AW+1-bit wrap pointers.
// Latency: push visible at the head one cycle later; a pop in the same cycle frees room for a push when full.
module io_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // When full with a pop, the write slot is the head being read out this cycle.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// CPU I/O port <-> uart_rx/uart_tx bridge: RX FIFO serves CPU "in", TX FIFO feeds uart_tx one frame at a time.
// CPU acks one cycle after a serviceable request; stalls only on RX empty / TX full. IO_CTRL_LOOPBACK_EN echoes RX into TX.
module uart_io_ctrl
  import io_pkg::*;
#(
  parameter int RX_AW = 9,
  parameter int TX_AW = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_ready,
  input  logic              i_rx_ferr,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  input  logic              i_cpu_in_req,
  output logic              o_cpu_in_ack,
  output logic [BYTE_W-1:0] o_cpu_in_data,
  input  logic              i_cpu_out_req,
  input  logic [BYTE_W-1:0] i_cpu_out_data,
  output logic              o_cpu_out_ack,
  output logic              o_rx_overrun,
  output logic              o_rx_ferr_seen
);

  logic [BYTE_W-1:0]   w_rx_head;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_rx_push;
  logic                w_rx_pop;
  logic                w_in_take;
  logic                r_in_ack;
  logic [BYTE_W-1:0]   r_in_data;

  logic [BYTE_W-1:0]   w_tx_head;
  logic [BYTE_W-1:0]   w_tx_din;
  logic                w_tx_full;
  logic                w_tx_empty;
  logic                w_tx_push;
  logic                w_tx_pop;
  logic                w_out_take;
  logic                r_out_ack;
  logic [BYTE_W-1:0]   r_out_data;

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_tx_start;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_rx_overrun;
  logic                r_rx_ferr_seen;

  assign w_rx_pop  = r_in_ack;
  assign w_rx_push = i_rx_ready && !i_rx_ferr && (!w_rx_full || w_rx_pop);
  assign w_in_take = i_cpu_in_req && !w_rx_empty && !r_in_ack;

  io_fifo #(.AW(RX_AW), .W(BYTE_W)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (i_rx_data),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_ack       <= 1'b0;
      r_in_data      <= '0;
      r_rx_overrun   <= 1'b0;
      r_rx_ferr_seen <= 1'b0;
    end else begin
      r_in_ack <= w_in_take;
      if (w_in_take) r_in_data <= w_rx_head;
      if (i_rx_ready && !i_rx_ferr && w_rx_full && !w_rx_pop) r_rx_overrun <= 1'b1;
      if (i_rx_ready && i_rx_ferr) r_rx_ferr_seen <= 1'b1;
    end
  end

  assign w_out_take = i_cpu_out_req && !w_tx_full && !r_out_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_ack  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_ack <= w_out_take;
      if (w_out_take) r_out_data <= i_cpu_out_data;
    end
  end

`ifdef IO_CTRL_LOOPBACK_EN
  logic w_echo_push;
  // The echo also yields to a CPU byte granted this cycle, so that byte's slot is never taken.
  assign w_echo_push = w_rx_push && !r_out_ack && !w_out_take && (!w_tx_full || w_tx_pop);
  assign w_tx_push   = r_out_ack || w_echo_push;
  assign w_tx_din    = r_out_ack ? r_out_data : i_rx_data;
`else
  assign w_tx_push   = r_out_ack;
  assign w_tx_din    = r_out_data;
`endif

  io_fifo #(.AW(TX_AW), .W(BYTE_W)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (w_tx_din),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    case (r_state)
      IDLE:      if (!w_tx_empty && !i_tx_busy) w_state_nxt = LOAD;
      LOAD: begin
        w_tx_pop    = 1'b1;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (i_tx_busy || busy_timed_out(r_to_cnt)) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (!i_tx_busy) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Start and data are registered together so uart_tx sees a stable byte with its strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (r_state == LOAD);
      if (r_state == LOAD) r_tx_data <= w_tx_head;
      r_to_cnt   <= (r_state == WAIT_BUSY) ? r_to_cnt + TO_CNT_W'(1) : '0;
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_tx_start     = r_tx_start;
  assign o_cpu_in_ack   = r_in_ack;
  assign o_cpu_in_data  = r_in_data;
  assign o_cpu_out_ack  = r_out_ack;
  assign o_rx_overrun   = r_rx_overrun;
  assign o_rx_ferr_seen = r_rx_ferr_seen;

endmodule
